hazard_control_unit: RTL

- Pipeline sequencing controller for the 7-stage core (IF, ID, EX, DM1, DM2, DM3, WB).
- Complements ALU-input forwarding by handling the cases forwarding cannot cover:
  - load-use hazards, where load data is forwardable only from WB;
  - taken-branch flushes;
  - data-memory wait freezes.
- Keeps an internal load scoreboard and a two-state memory-wait FSM.
- Drives the per-stage enable, bubble and flush controls.

---
 rtl/hazard_control_unit.sv | 117 +++++++++++
 1 files changed

// File: rtl/hazard_control_unit.sv
// Pipeline sequencing controller for the 7-stage core: load-use stalls, taken-branch
// flushes and data-memory wait freezes, plus a saturating stall-cycle counter.
module hazard_control_unit #(
    parameter int unsigned REG_ADDR_WIDTH  = 5,
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       ID_VALID,
    input  logic [REG_ADDR_WIDTH-1:0]  ID_RS1_ADDRESS,
    input  logic [REG_ADDR_WIDTH-1:0]  ID_RS2_ADDRESS,
    input  logic                       ID_USES_RS1,
    input  logic                       ID_USES_RS2,
    input  logic                       ID_IS_LOAD,
    input  logic [REG_ADDR_WIDTH-1:0]  ID_RD_ADDRESS,
    input  logic                       BRANCH_TAKEN_EX,
    input  logic                       DM_REQUEST,
    input  logic                       DATA_MEMORY_READY,
    output logic                       PC_ENABLE,
    output logic                       IF_ID_ENABLE,
    output logic                       ID_EX_ENABLE,
    output logic                       ID_EX_BUBBLE,
    output logic                       FLUSH_IF_ID,
    output logic [STALL_CNT_WIDTH-1:0] STALL_COUNT
);

    typedef enum logic [0:0] {StRun, StMemWait} state_t;

    localparam int unsigned SbDepth = 3;

    state_t                      state_q;
    logic [SbDepth-1:0]          sb_valid_q;
    logic [REG_ADDR_WIDTH-1:0]   sb_rd_q [SbDepth];
    logic [STALL_CNT_WIDTH-1:0]  stall_cnt_q;

    logic freeze;
    logic flush;
    logic load_use;
    logic sb_hit;
    logic count_en;

    always_comb begin
        freeze = ((state_q == StRun) && DM_REQUEST && !DATA_MEMORY_READY) ||
                 ((state_q == StMemWait) && !DATA_MEMORY_READY);
        flush  = BRANCH_TAKEN_EX && !freeze;
    end

    // Entries index EX, DM1, DM2; a load already in DM3 forwards from WB in time.
    always_comb begin
        sb_hit = 1'b0;
        for (int i = 0; i < SbDepth; i++) begin
            if (sb_valid_q[i] && (sb_rd_q[i] != '0) &&
                ((ID_USES_RS1 && (ID_RS1_ADDRESS == sb_rd_q[i])) ||
                 (ID_USES_RS2 && (ID_RS2_ADDRESS == sb_rd_q[i])))) begin
                sb_hit = 1'b1;
            end
        end
        load_use = ID_VALID && sb_hit;
        count_en = (freeze || load_use) && !flush && !RST;
    end

    always_comb begin
        PC_ENABLE    = 1'b1;
        IF_ID_ENABLE = 1'b1;
        ID_EX_ENABLE = 1'b1;
        ID_EX_BUBBLE = 1'b0;
        FLUSH_IF_ID  = 1'b0;
        if (RST) begin
            PC_ENABLE    = 1'b0;
            IF_ID_ENABLE = 1'b0;
            ID_EX_BUBBLE = 1'b1;
            FLUSH_IF_ID  = 1'b1;
        end else if (freeze) begin
            PC_ENABLE    = 1'b0;
            IF_ID_ENABLE = 1'b0;
            ID_EX_ENABLE = 1'b0;
        end else if (flush) begin
            ID_EX_BUBBLE = 1'b1;
            FLUSH_IF_ID  = 1'b1;
        end else if (load_use) begin
            PC_ENABLE    = 1'b0;
            IF_ID_ENABLE = 1'b0;
            ID_EX_BUBBLE = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StRun;
            sb_valid_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            unique case (state_q)
                StRun:     if (DM_REQUEST && !DATA_MEMORY_READY) state_q <= StMemWait;
                StMemWait: if (DATA_MEMORY_READY) state_q <= StRun;
                default:   state_q <= StRun;
            endcase

            if (!freeze) begin
                sb_valid_q[2] <= sb_valid_q[1];
                sb_rd_q[2]    <= sb_rd_q[1];
                sb_valid_q[1] <= sb_valid_q[0];
                sb_rd_q[1]    <= sb_rd_q[0];
                // A stalled or squashed load stays out of the scoreboard.
                sb_valid_q[0] <= ID_VALID && ID_IS_LOAD && !load_use && !flush;
                sb_rd_q[0]    <= ID_RD_ADDRESS;
            end

            if (count_en && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + STALL_CNT_WIDTH'(1);
            end
        end
    end

    assign STALL_COUNT = stall_cnt_q;

endmodule
